// File: rtl/fb_write_scheduler_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fb_write_scheduler_if : pixel request channel plus SDRAM Avalon-MM write bus
// Rev 1.0
// ---------------------------------------------------------------------------
interface fb_write_scheduler_if;
   logic        pix_valid;
   logic        pix_ready;
   logic [15:0] pix_x;
   logic [15:0] pix_y;
   logic [31:0] pix_rgba;
   logic        SD_waitrequest;
   logic        SD_write;
   logic [31:0] SD_wdata;
   logic [27:0] SD_address;

   // master: the scheduler (it masters the SDRAM bus and accepts pixels)
   modport master (
      input  pix_valid, pix_x, pix_y, pix_rgba, SD_waitrequest,
      output pix_ready, SD_write, SD_wdata, SD_address
   );

   // slave: rasteriser and SDRAM controller side
   modport slave (
      output pix_valid, pix_x, pix_y, pix_rgba, SD_waitrequest,
      input  pix_ready, SD_write, SD_wdata, SD_address
   );
endinterface
`default_nettype wire

// File: rtl/fb_write_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fb_write_scheduler : frame-buffer SDRAM write arbiter (clear > swap > pixel)
// Rev 1.0
// ---------------------------------------------------------------------------
module fb_write_scheduler #(
   parameter int unsigned H_RES       = 640,
   parameter int unsigned V_RES       = 480,
   parameter logic [27:0] FB0_BASE    = 28'h0000000,
   parameter logic [27:0] FB1_BASE    = 28'h0200000,
   parameter logic [31:0] CLEAR_COLOR = 32'h00000000
) (
   input  logic                clk,
   input  logic                reset,
   fb_write_scheduler_if.master bus,
   input  logic                clear_req,
   output logic                clear_busy,
   input  logic                frame_ready,
   output logic                front_buffer,
   output logic                swap_done,
   output logic                pix_dropped
);
   localparam int unsigned       NPIX     = H_RES * V_RES;
   localparam int unsigned       CNT_W    = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NPIX - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PIX_WR = 2'd1,
      CLR_WR = 2'd2,
      SWAP   = 2'd3
   } state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             clear_pending, swap_pending;
   logic             dispatch_clr, dispatch_swap;
   logic [15:0]      x_q, y_q;
   logic [31:0]      rgba_q;
   logic             handshake, on_screen, beat_done;
   logic [27:0]      back_base;
   logic [31:0]      pix_offset;

   // back_base can only change in SWAP, which never overlaps a bus write
   assign back_base     = front_buffer ? FB0_BASE : FB1_BASE;
   assign bus.pix_ready = (state == IDLE) & ~clear_pending & ~swap_pending;
   assign handshake     = bus.pix_valid & bus.pix_ready;
   assign on_screen     = (32'(bus.pix_x) < H_RES) && (32'(bus.pix_y) < V_RES);
   assign beat_done     = bus.SD_write & ~bus.SD_waitrequest;
   assign clear_busy    = clear_pending | (state == CLR_WR);
   assign swap_done     = (state == SWAP);
   assign pix_offset    = (32'(y_q) * H_RES + 32'(x_q)) << 2;

   always_comb begin
      state_nx       = state;
      cnt_nx         = cnt;
      dispatch_clr   = 1'b0;
      dispatch_swap  = 1'b0;
      bus.SD_write   = 1'b0;
      bus.SD_address = 28'h0;
      bus.SD_wdata   = 32'h0;
      unique case (state)
         IDLE: begin
            if (clear_pending) begin
               state_nx     = CLR_WR;
               dispatch_clr = 1'b1;
            end else if (swap_pending) begin
               state_nx      = SWAP;
               dispatch_swap = 1'b1;
            end else if (handshake && on_screen) begin
               state_nx = PIX_WR;
            end
         end
         PIX_WR: begin
            bus.SD_write   = 1'b1;
            bus.SD_address = back_base + pix_offset[27:0];
            bus.SD_wdata   = rgba_q;
            if (beat_done) begin
               state_nx = IDLE;
            end
         end
         CLR_WR: begin
            bus.SD_write   = 1'b1;
            bus.SD_address = back_base + (28'(cnt) << 2);
            bus.SD_wdata   = CLEAR_COLOR;
            if (beat_done) begin
               if (cnt == CNT_LAST) begin
                  state_nx = IDLE;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt + CNT_W'(1);
               end
            end
         end
         SWAP: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         cnt           <= '0;
         clear_pending <= 1'b0;
         swap_pending  <= 1'b0;
         front_buffer  <= 1'b0;
         pix_dropped   <= 1'b0;
         x_q           <= 16'h0;
         y_q           <= 16'h0;
         rgba_q        <= 32'h0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         pix_dropped <= handshake & ~on_screen;
         if (handshake) begin
            x_q    <= bus.pix_x;
            y_q    <= bus.pix_y;
            rgba_q <= bus.pix_rgba;
         end
         // a clear request while one is pending or running merges into it
         if (clear_req && !clear_busy) begin
            clear_pending <= 1'b1;
         end else if (dispatch_clr) begin
            clear_pending <= 1'b0;
         end
         if (frame_ready) begin
            swap_pending <= 1'b1;
         end else if (dispatch_swap) begin
            swap_pending <= 1'b0;
         end
         if (state == SWAP) begin
            front_buffer <= ~front_buffer;
         end
      end
   end
endmodule
`default_nettype wire
